// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// The optional count output is enabled by defining PRIO_ENC_COUNT_EN.
package prio_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Never returns 0, so a zero-width index bus cannot arise.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int c = 0;
        for (int i = 0; i < 64; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational lowest- or highest-set-bit finder over an N-bit vector.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = clog2_safe(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // The last match in scan order wins, so the scan runs away from the winning end.
    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_encoder_seq.sv
// Captures a request vector and serialises its set-bit indices over valid/ready.
// Define PRIO_ENC_COUNT_EN to add the cnt output (popcount of the captured vector).
module prio_encoder_seq
    import prio_enc_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = clog2_safe(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_vec,
    input  logic         en_n,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         busy,
    output logic         done,
`ifdef PRIO_ENC_COUNT_EN
    output logic [W:0]   cnt,
`endif
    output logic         none
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] mask_q, mask_d;
    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         none_q, none_d;

    logic         accept;
    logic [N-1:0] mask_clr;
    logic [N-1:0] pick_vec;
    logic [W-1:0] pick_idx;
    logic         pick_any;

    // y_q always names a set bit of mask_q while draining, so clearing it
    // and picking from the remainder gives the next index with no bubble.
    assign accept   = valid_q & ready;
    assign mask_clr = accept ? (mask_q & ~(ONE << y_q)) : mask_q;
    assign pick_vec = (state_q == IDLE) ? in_vec : mask_clr;

    prio_pick #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_pick (
        .vec (pick_vec),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef PRIO_ENC_COUNT_EN
    logic [W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && !en_n) begin
            cnt_d = (W+1)'(popcount(64'(in_vec)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        y_d     = y_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        none_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!en_n) begin
                    if (pick_any) begin
                        state_d = DRAIN;
                        mask_d  = in_vec;
                        y_d     = pick_idx;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    mask_d = mask_clr;
                    if (pick_any) begin
                        y_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        y_d     = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
                y_d     = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            none_q  <= none_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign none  = none_q;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Bench for prio_encoder_seq: N=8 LSB-first instance and N=12 MSB-first instance.
module tb_prio_encoder_seq;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int N2 = 12;
    localparam int W2 = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N2-1:0] in_vec = '0;
    logic          en_n   = 1'b1;
    logic          en_n2  = 1'b1;
    logic          ready  = 1'b0;

    logic [W-1:0]  y;
    logic          valid, busy, done, none;
    logic [W2-1:0] y2;
    logic          valid2, busy2, done2, none2;
`ifdef PRIO_ENC_COUNT_EN
    logic [W:0]    cnt;
    logic [W2:0]   cnt2;
`endif

    prio_encoder_seq #(.N(N), .MSB_FIRST(1'b0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vec (in_vec[N-1:0]),
        .en_n   (en_n),
        .ready  (ready),
        .y      (y),
        .valid  (valid),
        .busy   (busy),
        .done   (done),
`ifdef PRIO_ENC_COUNT_EN
        .cnt    (cnt),
`endif
        .none   (none)
    );

    prio_encoder_seq #(.N(N2), .MSB_FIRST(1'b1)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vec (in_vec),
        .en_n   (en_n2),
        .ready  (ready),
        .y      (y2),
        .valid  (valid2),
        .busy   (busy2),
        .done   (done2),
`ifdef PRIO_ENC_COUNT_EN
        .cnt    (cnt2),
`endif
        .none   (none2)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W2-1:0] exp_q[$];

    typedef struct {
        logic [7:0]  vec;
        int          n;
        logic [23:0] seq;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: indices of set bits in the documented order, plus their count.
    task automatic build_model(input bit sel, input logic [N2-1:0] v);
        exp_q.delete();
        if (!sel) begin
            for (int i = 0; i < N; i++) if (v[i]) exp_q.push_back(W2'(i));
        end else begin
            for (int i = N2 - 1; i >= 0; i--) if (v[i]) exp_q.push_back(W2'(i));
        end
    endtask

    function automatic int model_pop(input bit sel, input logic [N2-1:0] v);
        int c = 0;
        for (int i = 0; i < (sel ? N2 : N); i++) c += int'(v[i]);
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input bit sel, input logic [N2-1:0] v);
        in_vec = v;
        if (sel) en_n2 = 1'b0;
        else     en_n  = 1'b0;
        tick();
        en_n  = 1'b1;
        en_n2 = 1'b1;
    endtask

    // Consumes exp_q against the selected instance; called right after load().
    task automatic drain(input bit sel, input int pct, input logic [N2-1:0] v);
        int guard = 0;
`ifdef PRIO_ENC_COUNT_EN
        check("cnt_load", sel ? 64'(cnt2) : 64'(cnt), 64'(model_pop(sel, v)));
`endif
        if (exp_q.size() == 0) begin
            check("none_pulse",  sel ? 64'(none2)  : 64'(none),  64'd1);
            check("none_valid",  sel ? 64'(valid2) : 64'(valid), 64'd0);
            check("none_busy",   sel ? 64'(busy2)  : 64'(busy),  64'd0);
            check("none_done",   sel ? 64'(done2)  : 64'(done),  64'd0);
            tick();
            check("none_clear",  sel ? 64'(none2)  : 64'(none),  64'd0);
            return;
        end
        while (exp_q.size() > 0 && guard < 500) begin
            check("drain_valid", sel ? 64'(valid2) : 64'(valid), 64'd1);
            check("drain_busy",  sel ? 64'(busy2)  : 64'(busy),  64'd1);
            check("drain_y",     sel ? 64'(y2)     : 64'(y),     64'(exp_q[0]));
            check("drain_done",  sel ? 64'(done2)  : 64'(done),  64'd0);
            ready = ($urandom_range(0, 99) < pct);
            tick();
            guard++;
            if (ready) void'(exp_q.pop_front());
        end
        if (guard >= 500) check("drain_timeout", 64'd1, 64'd0);
        ready = 1'b0;
        check("end_done",  sel ? 64'(done2)  : 64'(done),  64'd1);
        check("end_valid", sel ? 64'(valid2) : 64'(valid), 64'd0);
        check("end_busy",  sel ? 64'(busy2)  : 64'(busy),  64'd0);
        check("end_y",     sel ? 64'(y2)     : 64'(y),     64'd0);
        tick();
        check("done_once", sel ? 64'(done2)  : 64'(done),  64'd0);
`ifdef PRIO_ENC_COUNT_EN
        check("cnt_held", sel ? 64'(cnt2) : 64'(cnt), 64'(model_pop(sel, v)));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [N2-1:0] v;

        tbl[0] = '{8'b1010_0110, 4, {12'd0, 3'd7, 3'd5, 3'd2, 3'd1}};
        tbl[1] = '{8'h01, 1, {21'd0, 3'd0}};
        tbl[2] = '{8'h80, 1, {21'd0, 3'd7}};
        tbl[3] = '{8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        tbl[4] = '{8'h00, 0, 24'd0};
        tbl[5] = '{8'h24, 2, {18'd0, 3'd5, 3'd2}};

        repeat (3) tick();
        check("rst_y",     64'(y),     64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_none",  64'(none),  64'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a drain.
        load(1'b0, 12'h0F0);
        ready = 1'b1;
        tick();
        check("mid_y_before_rst", 64'(y), 64'd5);
        rst_n = 1'b0;
        #1;
        check("midrst_y",     64'(y),     64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_busy",  64'(busy),  64'd0);
        check("midrst_done",  64'(done),  64'd0);
        check("midrst_none",  64'(none),  64'd0);
`ifdef PRIO_ENC_COUNT_EN
        check("midrst_cnt",   64'(cnt),   64'd0);
`endif
        ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_done",  64'(done),  64'd0);
        check("postrst_valid", 64'(valid), 64'd0);
        check("postrst_busy",  64'(busy),  64'd0);

        // Table vectors at full throughput.
        for (int i = 0; i < 6; i++) begin
            exp_q.delete();
            for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(W2'(tbl[i].seq[3*k +: 3]));
            load(1'b0, {4'd0, tbl[i].vec});
            drain(1'b0, 100, {4'd0, tbl[i].vec});
        end

        // Backpressure holds y.
        load(1'b0, 12'h081);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", 64'(valid), 64'd1);
            check("bp_y",     64'(y),     64'd0);
            tick();
        end
        check("bp_y_held", 64'(y), 64'd0);
        ready = 1'b1;
        tick();
        check("bp_y_next", 64'(y),     64'd7);
        check("bp_valid2", 64'(valid), 64'd1);
        tick();
        check("bp_done",   64'(done),  64'd1);
        check("bp_busy",   64'(busy),  64'd0);
        ready = 1'b0;
        tick();
        check("bp_done_clear", 64'(done), 64'd0);

        // Load while busy is ignored; load on the final accept edge is ignored too.
        load(1'b0, 12'h00C);
        check("ov_first", 64'(y), 64'd2);
        ready  = 1'b1;
        in_vec = 12'h0F0;
        en_n   = 1'b0;
        tick();
        check("ov_y_unchanged", 64'(y),    64'd3);
        check("ov_busy",        64'(busy), 64'd1);
        in_vec = 12'h001;
        tick();
        check("ov_final_done",  64'(done),  64'd1);
        check("ov_final_valid", 64'(valid), 64'd0);
        check("ov_final_busy",  64'(busy),  64'd0);
        tick();
        check("ov_reload_valid", 64'(valid), 64'd1);
        check("ov_reload_y",     64'(y),     64'd0);
        check("ov_reload_busy",  64'(busy),  64'd1);
        check("ov_reload_done",  64'(done),  64'd0);
        en_n = 1'b1;
        tick();
        check("ov_reload_end", 64'(done), 64'd1);
        ready = 1'b0;
        tick();

        // MSB-first, N=12.
        exp_q.delete();
        exp_q.push_back(4'd11);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd0);
        load(1'b1, 12'h901);
        drain(1'b1, 100, 12'h901);

        // Randomised runs against the reference model.
        for (int r = 0; r < 40; r++) begin
            v = ($urandom_range(0, 7) == 0) ? 12'h000 : N2'($urandom_range(0, 255));
            build_model(1'b0, v);
            load(1'b0, v);
            drain(1'b0, $urandom_range(30, 100), v);
        end
        for (int r = 0; r < 30; r++) begin
            v = ($urandom_range(0, 7) == 0) ? 12'h000 : N2'($urandom_range(0, 4095));
            build_model(1'b1, v);
            load(1'b1, v);
            drain(1'b1, $urandom_range(30, 100), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
